// File: rtl/mac_accumulate_ctrl.sv
// Accumulates a vector of unsigned 16-bit products into one ACC_W-bit dot-product result.
// in_ready/out_valid are pure state decodes; the result is held in DONE until out_ready.
module mac_accumulate_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [15:0]      mul,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_adj;
  logic             accept;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;
  assign accept    = in_valid & in_ready;

  // Carry out of the extra MSB is the overflow event; an all-ones acc re-saturates on any add.
  assign sum     = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, mul};
  assign sum_adj = (SAT && sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ovf_d = 1'b0;
            if (vec_len != '0) begin
              len_d   = vec_len;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_ACC;
            end else begin
              out_data_d = '0;
              state_d    = S_DONE;
            end
          end
        end
        S_ACC: begin
          if (accept) begin
            acc_d = sum_adj;
            cnt_d = cnt_q + LEN_W'(1);
            ovf_d = ovf_q | sum[ACC_W];
            if (cnt_q == len_q - LEN_W'(1)) begin
              out_data_d = sum_adj;
              state_d    = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
